calc1_req_driver: RTL and testbench

- Upstream request driver for one calc1 port.
- Accepts a complete transaction (command plus two operands) over a valid/ready handshake.
- Serialises it onto the calc1 two-cycle request protocol: command with operand 1, then command 0 with operand 2.
- Waits for the port response and returns result, response code and timeout status to the bench or sequencer through a second valid/ready handshake.

---
 rtl/calc1_req_driver_if.sv | 34 +++
 rtl/calc1_req_driver.sv | 143 ++++++++++++++
 tb/tb_calc1_req_driver.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc1_req_driver_if.sv
// Handshake and port bundle between the calc1 request driver and its environment.
// master = the driver itself, slave = sequencer/bench plus the calc1 port.
interface calc1_req_driver_if #(
  parameter int STRAY_W = 8
);
  logic               txn_valid;
  logic               txn_ready;
  logic [3:0]         txn_cmd;
  logic [31:0]        txn_op1;
  logic [31:0]        txn_op2;
  logic [3:0]         req_cmd_out;
  logic [31:0]        req_data_out;
  logic [1:0]         resp_in;
  logic [31:0]        resp_data_in;
  logic               done_valid;
  logic               done_ready;
  logic [1:0]         done_resp;
  logic [31:0]        done_data;
  logic               done_timeout;
  logic               busy;
  logic [STRAY_W-1:0] stray_cnt;

  modport master (
    input  txn_valid, txn_cmd, txn_op1, txn_op2, resp_in, resp_data_in, done_ready,
    output txn_ready, req_cmd_out, req_data_out, done_valid, done_resp, done_data,
           done_timeout, busy, stray_cnt
  );

  modport slave (
    output txn_valid, txn_cmd, txn_op1, txn_op2, resp_in, resp_data_in, done_ready,
    input  txn_ready, req_cmd_out, req_data_out, done_valid, done_resp, done_data,
           done_timeout, busy, stray_cnt
  );
endinterface

// File: rtl/calc1_req_driver.sv
// Serialises one upstream transaction onto the calc1 two-cycle request protocol
// and returns the port response (or a timeout) through a done handshake.
//
// state | meaning
// IDLE  | ready for a transaction, port quiet
// SEND1 | command + operand 1 on the port
// SEND2 | command 0 + operand 2 on the port
// WAIT  | timing the port response
// DONE  | result held until done_ready
module calc1_req_driver #(
  parameter int TIMEOUT = 64,
  parameter int STRAY_W = 8
) (
  input  logic          c_clk,
  input  logic          reset,
  calc1_req_driver_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND1 = 3'd1,
    S_SEND2 = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [STRAY_W-1:0] STRAY_ONE = {{(STRAY_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [31:0]        op2_q, op2_d;
  logic               txn_ready_q, txn_ready_d;
  logic [3:0]         req_cmd_q, req_cmd_d;
  logic [31:0]        req_data_q, req_data_d;
  logic               done_valid_q, done_valid_d;
  logic [1:0]         done_resp_q, done_resp_d;
  logic [31:0]        done_data_q, done_data_d;
  logic               done_timeout_q, done_timeout_d;
  logic               busy_q, busy_d;
  logic [STRAY_W-1:0] stray_cnt_q, stray_cnt_d;
  logic               resp_seen;

  always_comb begin
    resp_seen      = (bus.resp_in != 2'd0);
    state_d        = state_q;
    timer_d        = timer_q;
    op2_d          = op2_q;
    req_cmd_d      = 4'd0;
    req_data_d     = 32'd0;
    done_resp_d    = done_resp_q;
    done_data_d    = done_data_q;
    done_timeout_d = done_timeout_q;
    stray_cnt_d    = stray_cnt_q;

    case (state_q)
      S_IDLE: begin
        // Phase 1 is driven straight from the accepted inputs, so only op2 needs latching.
        if (bus.txn_valid && txn_ready_q) begin
          op2_d      = bus.txn_op2;
          req_cmd_d  = bus.txn_cmd;
          req_data_d = bus.txn_op1;
          state_d    = S_SEND1;
        end
      end
      S_SEND1: begin
        req_data_d = op2_q;
        state_d    = S_SEND2;
      end
      S_SEND2: begin
        timer_d = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_seen) begin
          done_resp_d    = bus.resp_in;
          done_data_d    = bus.resp_data_in;
          done_timeout_d = 1'b0;
          state_d        = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          done_resp_d    = 2'd0;
          done_data_d    = 32'd0;
          done_timeout_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        if (bus.done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (resp_seen && (state_q != S_WAIT) && (stray_cnt_q != {STRAY_W{1'b1}}))
      stray_cnt_d = stray_cnt_q + STRAY_ONE;

    txn_ready_d  = (state_d == S_IDLE);
    done_valid_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timer_q        <= 8'd0;
      op2_q          <= 32'd0;
      txn_ready_q    <= 1'b0;
      req_cmd_q      <= 4'd0;
      req_data_q     <= 32'd0;
      done_valid_q   <= 1'b0;
      done_resp_q    <= 2'd0;
      done_data_q    <= 32'd0;
      done_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
      stray_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      op2_q          <= op2_d;
      txn_ready_q    <= txn_ready_d;
      req_cmd_q      <= req_cmd_d;
      req_data_q     <= req_data_d;
      done_valid_q   <= done_valid_d;
      done_resp_q    <= done_resp_d;
      done_data_q    <= done_data_d;
      done_timeout_q <= done_timeout_d;
      busy_q         <= busy_d;
      stray_cnt_q    <= stray_cnt_d;
    end
  end

  assign bus.txn_ready    = txn_ready_q;
  assign bus.req_cmd_out  = req_cmd_q;
  assign bus.req_data_out = req_data_q;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_resp    = done_resp_q;
  assign bus.done_data    = done_data_q;
  assign bus.done_timeout = done_timeout_q;
  assign bus.busy         = busy_q;
  assign bus.stray_cnt    = stray_cnt_q;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: acts as sequencer and calc1 port, checks against
// a transaction-level model of the expected done results and stray count.
module tb_calc1_req_driver;
  localparam int TIMEOUT = 64;
  localparam int STRAY_W = 8;
  localparam int STRAY_MAX = (1 << STRAY_W) - 1;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  always #5 c_clk = ~c_clk;

  calc1_req_driver_if #(.STRAY_W(STRAY_W)) bus();

  calc1_req_driver #(.TIMEOUT(TIMEOUT), .STRAY_W(STRAY_W)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int stray_exp = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          resp_at;   // WAIT cycle (1-based) the port answers; 0 = never
    logic [1:0]  code;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic        exp_to;
    int          exp_wait;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // calc1 port behaviour as seen by the bench
  function automatic void port_model(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, output bit responds,
                                     output logic [1:0] code, output logic [31:0] data);
    logic [32:0] s;
    responds = 1'b1;
    code     = 2'd1;
    data     = 32'd0;
    case (cmd)
      4'd0: responds = 1'b0;
      4'd1: begin s = {1'b0, a} + {1'b0, b}; data = s[31:0]; code = s[32] ? 2'd2 : 2'd1; end
      4'd2: begin data = a - b; code = (b > a) ? 2'd2 : 2'd1; end
      4'd5: data = a << b[4:0];
      4'd6: data = a >> b[4:0];
      default: code = 2'd3;
    endcase
  endfunction

  // What the driver must report for a port that answers at WAIT cycle resp_at
  function automatic void drv_model(input bit responds, input int resp_at,
                                    input logic [1:0] code, input logic [31:0] data,
                                    output logic [1:0] e_resp, output logic [31:0] e_data,
                                    output logic e_to, output int e_wait);
    if (responds && code != 2'd0 && resp_at >= 1 && resp_at <= TIMEOUT) begin
      e_resp = code; e_data = data; e_to = 1'b0; e_wait = resp_at;
    end else begin
      e_resp = 2'd0; e_data = 32'd0; e_to = 1'b1; e_wait = TIMEOUT;
    end
  endfunction

  task automatic stray_bump();
    if (stray_exp < STRAY_MAX) stray_exp++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " txn_ready"},    64'(bus.txn_ready), 64'd0);
    chk({tag, " req_cmd"},      64'(bus.req_cmd_out), 64'd0);
    chk({tag, " req_data"},     64'(bus.req_data_out), 64'd0);
    chk({tag, " done_valid"},   64'(bus.done_valid), 64'd0);
    chk({tag, " done_resp"},    64'(bus.done_resp), 64'd0);
    chk({tag, " done_data"},    64'(bus.done_data), 64'd0);
    chk({tag, " done_timeout"}, 64'(bus.done_timeout), 64'd0);
    chk({tag, " busy"},         64'(bus.busy), 64'd0);
    chk({tag, " stray_cnt"},    64'(bus.stray_cnt), 64'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge c_clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    stray_exp = 0;
    @(negedge c_clk);
    chk("ready after reset", 64'(bus.txn_ready), 64'd1);
  endtask

  // Offers a transaction, checks both request phases; returns in WAIT cycle 1.
  task automatic send_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
    int k;
    for (k = 0; k < 20 && bus.txn_ready !== 1'b1; k++) @(negedge c_clk);
    if (k == 20) chk("txn_ready wait expired", 64'(bus.txn_ready), 64'd1);
    bus.txn_valid = 1'b1;
    bus.txn_cmd   = cmd;
    bus.txn_op1   = op1;
    bus.txn_op2   = op2;
    @(negedge c_clk);
    bus.txn_valid = 1'b0;
    bus.txn_cmd   = 4'($urandom);
    bus.txn_op1   = $urandom;
    bus.txn_op2   = $urandom;
    chk("phase1 cmd",  64'(bus.req_cmd_out), 64'(cmd));
    chk("phase1 data", 64'(bus.req_data_out), 64'(op1));
    chk("phase1 ready", 64'(bus.txn_ready), 64'd0);
    chk("phase1 busy",  64'(bus.busy), 64'd1);
    @(negedge c_clk);
    chk("phase2 cmd",  64'(bus.req_cmd_out), 64'd0);
    chk("phase2 data", 64'(bus.req_data_out), 64'(op2));
    @(negedge c_clk);
    chk("wait req quiet", 64'({bus.req_cmd_out, bus.req_data_out}), 64'd0);
  endtask

  // Plays the port through WAIT; waited = WAIT cycles until done_valid.
  task automatic wait_done(input int resp_at, input logic [1:0] code,
                           input logic [31:0] data, output int waited);
    waited = 0;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      bus.resp_in      = (k == resp_at) ? code : 2'd0;
      bus.resp_data_in = (k == resp_at) ? data : $urandom;
      @(negedge c_clk);
      bus.resp_in = 2'd0;
      if (bus.done_valid === 1'b1) begin
        waited = k;
        break;
      end
    end
    if (waited == 0) chk("done_valid wait expired", 64'(bus.done_valid), 64'd1);
  endtask

  task automatic check_done(input string tag, input logic [1:0] r, input logic [31:0] d, input logic t);
    chk({tag, " done_valid"},   64'(bus.done_valid), 64'd1);
    chk({tag, " done_resp"},    64'(bus.done_resp), 64'(r));
    chk({tag, " done_data"},    64'(bus.done_data), 64'(d));
    chk({tag, " done_timeout"}, 64'(bus.done_timeout), 64'(t));
  endtask

  // Holds done_ready low for n cycles, optionally pulsing stray responses.
  task automatic hold_done(input int n, input int pa, input int pb, input bit rnd,
                           input logic [1:0] r, input logic [31:0] d, input logic t);
    for (int i = 1; i <= n; i++) begin
      if (i == pa || i == pb || (rnd && $urandom_range(0, 3) == 0)) begin
        bus.resp_in = 2'($urandom_range(1, 3));
        stray_bump();
      end
      bus.resp_data_in = $urandom;
      @(negedge c_clk);
      bus.resp_in = 2'd0;
      chk("hold ready low", 64'(bus.txn_ready), 64'd0);
      check_done("hold", r, d, t);
    end
  endtask

  task automatic ack_done();
    bus.done_ready = 1'b1;
    @(negedge c_clk);
    bus.done_ready = 1'b0;
    chk("ack done_valid", 64'(bus.done_valid), 64'd0);
    chk("ack txn_ready",  64'(bus.txn_ready), 64'd1);
    chk("ack busy",       64'(bus.busy), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [1:0]  e_resp, p_code;
    logic [31:0] e_data, p_data;
    logic        e_to;
    int          e_wait, waited, resp_at;
    bit          responds;
    logic [3:0]  cmd_pool[8];
    logic [3:0]  cmd;
    logic [31:0] a, b, x;

    bus.txn_valid = 1'b0;  bus.txn_cmd = 4'd0;  bus.txn_op1 = 32'd0;  bus.txn_op2 = 32'd0;
    bus.resp_in = 2'd0;    bus.resp_data_in = 32'd0;  bus.done_ready = 1'b0;

    //          cmd    op1           op2    at  code   data           e_resp e_data         to  wait
    vecs[0] = '{4'd1,  32'd1,        32'd1, 3,  2'd1,  32'd2,         2'd1,  32'd2,         1'b0, 3};
    vecs[1] = '{4'd2,  32'd9,        32'd4, 1,  2'd1,  32'd5,         2'd1,  32'd5,         1'b0, 1};
    vecs[2] = '{4'd0,  32'h1234,     32'd7, 0,  2'd0,  32'd0,         2'd0,  32'd0,         1'b1, 64};
    vecs[3] = '{4'd2,  32'd0,        32'd1, 64, 2'd2,  32'hFFFF_FFFF, 2'd2,  32'hFFFF_FFFF, 1'b0, 64};
    vecs[4] = '{4'd1,  32'd3,        32'd4, 65, 2'd1,  32'd7,         2'd0,  32'd0,         1'b1, 64};
    vecs[5] = '{4'd11, 32'hDEAD,     32'd1, 2,  2'd3,  32'hABCD,      2'd3,  32'hABCD,      1'b0, 2};

    do_reset(4);

    for (int i = 0; i < 6; i++) begin
      send_txn(vecs[i].cmd, vecs[i].op1, vecs[i].op2);
      wait_done(vecs[i].resp_at, vecs[i].code, vecs[i].data, waited);
      chk($sformatf("vec%0d wait cycles", i), 64'(waited), 64'(vecs[i].exp_wait));
      check_done($sformatf("vec%0d", i), vecs[i].exp_resp, vecs[i].exp_data, vecs[i].exp_to);
      ack_done();
    end
    chk("table stray", 64'(bus.stray_cnt), 64'd0);

    // walking-ones add
    for (int s = 0; s < 31; s++) begin
      x = 32'd1 << s;
      send_txn(4'd1, x, 32'd0);
      port_model(4'd1, x, 32'd0, responds, p_code, p_data);
      wait_done(2, p_code, p_data, waited);
      check_done("walk", 2'd1, x, 1'b0);
      ack_done();
    end
    chk("walk stray", 64'(bus.stray_cnt), 64'd0);

    // backpressure with two stray pulses
    do_reset(2);
    send_txn(4'd1, 32'd10, 32'd20);
    wait_done(4, 2'd1, 32'd30, waited);
    check_done("bp", 2'd1, 32'd30, 1'b0);
    hold_done(10, 3, 7, 1'b0, 2'd1, 32'd30, 1'b0);
    chk("bp stray", 64'(bus.stray_cnt), 64'd2);
    ack_done();

    // reset in WAIT cycle 5
    send_txn(4'd1, 32'd5, 32'd6);
    repeat (4) @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    reset = 1'b0;
    stray_exp = 0;
    check_reset_outputs("midrst");
    @(negedge c_clk);
    chk("midrst no done", 64'(bus.done_valid), 64'd0);
    @(negedge c_clk);
    bus.resp_in = 2'd1;
    bus.resp_data_in = 32'd11;
    @(negedge c_clk);
    bus.resp_in = 2'd0;
    chk("midrst no done late", 64'(bus.done_valid), 64'd0);
    chk("midrst stray", 64'(bus.stray_cnt), 64'd1);
    stray_exp = 1;

    // randomized transactions against the model
    cmd_pool = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9, 4'd15};
    for (int n = 0; n < 40; n++) begin
      cmd = (n % 10 == 9) ? cmd_pool[$urandom_range(0, 7)] : cmd_pool[$urandom_range(1, 4)];
      a = $urandom;
      b = (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      resp_at = $urandom_range(1, TIMEOUT + 6);
      if (n % 8 == 0) resp_at = $urandom_range(1, 3);
      port_model(cmd, a, b, responds, p_code, p_data);
      drv_model(responds, resp_at, p_code, p_data, e_resp, e_data, e_to, e_wait);
      send_txn(cmd, a, b);
      wait_done(responds ? resp_at : 0, p_code, p_data, waited);
      chk("rand wait cycles", 64'(waited), 64'(e_wait));
      check_done("rand", e_resp, e_data, e_to);
      hold_done($urandom_range(0, 4), 0, 0, 1'b1, e_resp, e_data, e_to);
      ack_done();
      chk("rand stray", 64'(bus.stray_cnt), 64'(stray_exp));
    end

    // stray counter saturation in IDLE
    do_reset(1);
    bus.resp_in = 2'd1;
    for (int i = 0; i < STRAY_MAX + 5; i++) begin
      @(negedge c_clk);
      stray_bump();
    end
    bus.resp_in = 2'd0;
    chk("stray saturate", 64'(bus.stray_cnt), 64'(stray_exp));
    chk("stray saturate all-ones", 64'(bus.stray_cnt), 64'(STRAY_MAX));
    chk("stray idle ready", 64'(bus.txn_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
